mem_stage: RTL and testbench

- Memory-access stage of the RISC-V/neuromorphic pipeline. It sits directly downstream of the EX/MEM register and consumes that register's outputs.
- Resolves branches combinationally.
- Runs load/store traffic to the data memory over a req/ack handshake, with a timeout.
- Stalls the upstream pipeline while an access is outstanding.
- Registers the MEM/WB pipeline values, including the WVR/SVR write enables.

---
 rtl/mem_stage.sv | 158 +++++++++++++++
 tb/tb_mem_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Memory-access pipeline stage. Resolves branches, runs data-memory
//            req/ack traffic with a timeout, stalls upstream and drives MEM/WB.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adder_in,
  input  logic        zero_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] writedata_in,
  input  logic [4:0]  rd_in,
  input  logic        branch_in,
  input  logic        memtoreg_in,
  input  logic        memwrite_in,
  input  logic        regwrite_in,
  input  logic        WVRwrite_in,
  input  logic        SVRwrite_in,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        bus_error,
  output logic [31:0] readdata_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        memtoreg_out,
  output logic        regwrite_out,
  output logic        WVRwrite_out,
  output logic        SVRwrite_out
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;
  localparam logic [7:0] c_LAST = 8'(ACK_TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_count;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_bus_error;
  logic [31:0] r_readdata;
  logic [31:0] r_alu;
  logic [4:0]  r_rd;
  logic        r_memtoreg;
  logic        r_regwrite;
  logic        r_wvr;
  logic        r_svr;
  logic        w_memop;

  assign w_memop       = memtoreg_in | memwrite_in;
  assign pcsrc         = branch_in & zero_in;
  assign branch_target = adder_in;
  // Gated by reset so an aborted access releases upstream immediately.
  assign stall = ~reset & (((r_state == c_IDLE) & w_memop) | (r_state == c_BUSY));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_count     <= 8'd0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_bus_error <= 1'b0;
      r_readdata  <= 32'd0;
      r_alu       <= 32'd0;
      r_rd        <= 5'd0;
      r_memtoreg  <= 1'b0;
      r_regwrite  <= 1'b0;
      r_wvr       <= 1'b0;
      r_svr       <= 1'b0;
    end else begin
      // MEM/WB defaults to a bubble; only retiring instructions override it.
      r_bus_error <= 1'b0;
      r_readdata  <= 32'd0;
      r_alu       <= 32'd0;
      r_rd        <= 5'd0;
      r_memtoreg  <= 1'b0;
      r_regwrite  <= 1'b0;
      r_wvr       <= 1'b0;
      r_svr       <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_memop) begin
            r_req   <= 1'b1;
            r_we    <= memwrite_in;
            r_addr  <= alu_result_in;
            r_wdata <= writedata_in;
            r_count <= 8'd0;
            r_state <= c_BUSY;
          end else begin
            r_alu      <= alu_result_in;
            r_rd       <= rd_in;
            r_memtoreg <= memtoreg_in;
            r_regwrite <= regwrite_in;
            r_wvr      <= WVRwrite_in;
            r_svr      <= SVRwrite_in;
          end
        end
        c_BUSY: begin
          if (dmem_ack) begin
            r_req      <= 1'b0;
            r_readdata <= memtoreg_in ? dmem_rdata : 32'd0;
            r_alu      <= alu_result_in;
            r_rd       <= rd_in;
            r_memtoreg <= memtoreg_in;
            r_regwrite <= regwrite_in;
            r_wvr      <= WVRwrite_in;
            r_svr      <= SVRwrite_in;
            r_state    <= c_DONE;
          end else if (r_count == c_LAST) begin
            r_req       <= 1'b0;
            r_bus_error <= 1'b1;
            r_state     <= c_DONE;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign dmem_req       = r_req;
  assign dmem_we        = r_we;
  assign dmem_addr      = r_addr;
  assign dmem_wdata     = r_wdata;
  assign bus_error      = r_bus_error;
  assign readdata_out   = r_readdata;
  assign alu_result_out = r_alu;
  assign rd_out         = r_rd;
  assign memtoreg_out   = r_memtoreg;
  assign regwrite_out   = r_regwrite;
  assign WVRwrite_out   = r_wvr;
  assign SVRwrite_out   = r_svr;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Randomized self-checking bench for mem_stage with a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adder_in, alu_result_in, writedata_in, dmem_rdata;
  logic [4:0]  rd_in;
  logic        zero_in, branch_in, memtoreg_in, memwrite_in, regwrite_in;
  logic        WVRwrite_in, SVRwrite_in, dmem_ack;
  logic        dmem_req, dmem_we, stall, pcsrc, bus_error;
  logic [31:0] dmem_addr, dmem_wdata, branch_target, readdata_out, alu_result_out;
  logic [4:0]  rd_out;
  logic        memtoreg_out, regwrite_out, WVRwrite_out, SVRwrite_out;

  always #5 clk = ~clk;

  mem_stage #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .adder_in(adder_in), .zero_in(zero_in),
    .alu_result_in(alu_result_in), .writedata_in(writedata_in), .rd_in(rd_in),
    .branch_in(branch_in), .memtoreg_in(memtoreg_in), .memwrite_in(memwrite_in),
    .regwrite_in(regwrite_in), .WVRwrite_in(WVRwrite_in), .SVRwrite_in(SVRwrite_in),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .stall(stall), .pcsrc(pcsrc), .branch_target(branch_target),
    .bus_error(bus_error), .readdata_out(readdata_out),
    .alu_result_out(alu_result_out), .rd_out(rd_out),
    .memtoreg_out(memtoreg_out), .regwrite_out(regwrite_out),
    .WVRwrite_out(WVRwrite_out), .SVRwrite_out(SVRwrite_out)
  );

  typedef struct packed {
    logic [31:0] rdat;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        m2r, rw, wvr, svr;
  } wb_t;

  typedef struct {
    logic [31:0] alu, wdata, adder, rdata;
    logic [4:0]  rd;
    logic        br, zero, m2r, mw, rw, wvr, svr;
    int          d;  // BUSY cycles before ack; d >= T means no ack at all
  } op_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected values for the current cycle, written by the driver.
  logic        e_valid, e_stall, e_req, e_we, e_berr, e_pcsrc;
  logic [31:0] e_addr, e_wdata, e_target;
  wb_t         e_wb, carry;

  always @(negedge clk) begin
    if (e_valid) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("dmem_req", 32'(dmem_req), 32'(e_req));
      if (e_req) begin
        chk("dmem_we", 32'(dmem_we), 32'(e_we));
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      chk("bus_error", 32'(bus_error), 32'(e_berr));
      chk("pcsrc", 32'(pcsrc), 32'(e_pcsrc));
      chk("branch_target", branch_target, e_target);
      chk("readdata_out", readdata_out, e_wb.rdat);
      chk("alu_result_out", alu_result_out, e_wb.alu);
      chk("rd_out", 32'(rd_out), 32'(e_wb.rd));
      chk("wb_ctl", 32'({memtoreg_out, regwrite_out, WVRwrite_out, SVRwrite_out}),
          32'({e_wb.m2r, e_wb.rw, e_wb.wvr, e_wb.svr}));
    end
  end

  int obs_stall, obs_req, obs_berr, cyc;
  logic [31:0] snap_rdat;
  logic snap_m2r, snap_rw;

  task automatic apply(input op_t o);
    adder_in = o.adder; zero_in = o.zero; alu_result_in = o.alu;
    writedata_in = o.wdata; rd_in = o.rd; branch_in = o.br;
    memtoreg_in = o.m2r; memwrite_in = o.mw; regwrite_in = o.rw;
    WVRwrite_in = o.wvr; SVRwrite_in = o.svr;
  endtask

  // Timeline of one instruction: cycle 0 is presentation in IDLE, cycles
  // 1..nb are BUSY, cycle nb+1 is DONE. Non-memory ops occupy cycle 0 only.
  task automatic run_op(input op_t o);
    int nb;
    logic memop, tmo;
    memop = o.m2r | o.mw;
    tmo   = memop && (o.d >= T);
    nb    = !memop ? 0 : (tmo ? T : o.d + 1);
    obs_stall = 0; obs_req = 0; obs_berr = 0; cyc = 0;
    for (int k = 0; k <= (memop ? nb + 1 : 0); k++) begin
      apply(o);
      if (memop && k >= 1 && k <= nb) begin
        dmem_ack   = (k == o.d + 1);
        dmem_rdata = (k == o.d + 1) ? o.rdata : $urandom;
      end else begin
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
      e_stall  = memop && (k <= nb);
      e_req    = memop && (k >= 1) && (k <= nb);
      e_we     = o.mw;
      e_addr   = o.alu;
      e_wdata  = o.wdata;
      e_berr   = tmo && (k == nb + 1);
      e_pcsrc  = o.br & o.zero;
      e_target = o.adder;
      if (k == 0)
        e_wb = carry;
      else if (k <= nb || tmo)
        e_wb = '0;
      else
        e_wb = wb_t'{rdat: (o.m2r ? o.rdata : 32'd0), alu: o.alu, rd: o.rd,
                     m2r: o.m2r, rw: o.rw, wvr: o.wvr, svr: o.svr};
      e_valid = 1'b1;
      #1;
      obs_stall += int'(stall);
      obs_req   += int'(dmem_req);
      obs_berr  += int'(bus_error);
      cyc++;
      if (memop && k == nb + 1) begin
        snap_rdat = readdata_out; snap_m2r = memtoreg_out; snap_rw = regwrite_out;
      end
      @(posedge clk); #1;
    end
    carry = memop ? wb_t'('0)
                  : wb_t'{rdat: 32'd0, alu: o.alu, rd: o.rd, m2r: o.m2r,
                          rw: o.rw, wvr: o.wvr, svr: o.svr};
  endtask

  function automatic op_t blank_op();
    op_t o;
    o.alu = 0; o.wdata = 0; o.adder = 0; o.rdata = 0; o.rd = 0;
    o.br = 0; o.zero = 0; o.m2r = 0; o.mw = 0; o.rw = 0; o.wvr = 0; o.svr = 0;
    o.d = 0;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int kind;
    kind    = $urandom_range(0, 9);
    o       = blank_op();
    o.alu   = $urandom; o.wdata = $urandom; o.adder = $urandom; o.rdata = $urandom;
    o.rd    = 5'($urandom); o.br = 1'($urandom); o.zero = 1'($urandom);
    o.wvr   = 1'($urandom); o.svr = 1'($urandom);
    o.d     = $urandom_range(0, T + 1);
    if (kind < 4) o.rw = 1'($urandom);
    else if (kind < 7) begin o.m2r = 1'b1; o.rw = 1'b1; end
    else o.mw = 1'b1;
    return o;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    int tot_cyc, tot_req;
    reset = 1'b1;
    apply(blank_op());
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    e_valid = 1'b1; e_stall = 0; e_req = 0; e_we = 0; e_berr = 0; e_pcsrc = 0;
    e_addr = 0; e_wdata = 0; e_target = 0; e_wb = '0; carry = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", 32'(dmem_req), 32'd0);
    chk("reset_readdata", readdata_out, 32'd0);
    reset = 1'b0;

    // ALU op passes straight through in one cycle
    o = blank_op(); o.alu = 32'h10; o.rd = 5'd5; o.rw = 1'b1;
    run_op(o);
    chk("alu_lit_result", alu_result_out, 32'h10);
    chk("alu_lit_rd", 32'(rd_out), 32'd5);
    chk("alu_lit_rw", 32'(regwrite_out), 32'd1);
    chk("alu_lit_stall", 32'(obs_stall), 32'd0);

    // Branch resolves in the same cycle and never stalls
    o = blank_op(); o.br = 1'b1; o.zero = 1'b1; o.adder = 32'h40;
    apply(o); #1;
    chk("br_lit_pcsrc", 32'(pcsrc), 32'd1);
    chk("br_lit_target", branch_target, 32'h40);
    run_op(o);
    chk("br_lit_stall", 32'(obs_stall), 32'd0);

    // Zero-wait load
    o = blank_op(); o.alu = 32'h100; o.m2r = 1'b1; o.rw = 1'b1; o.rd = 5'd7;
    o.rdata = 32'hDEADBEEF; o.d = 0;
    run_op(o);
    chk("ld_lit_stall", 32'(obs_stall), 32'd2);
    chk("ld_lit_req", 32'(obs_req), 32'd1);
    chk("ld_lit_rdat", snap_rdat, 32'hDEADBEEF);
    chk("ld_lit_ctl", 32'({snap_m2r, snap_rw}), 32'd3);
    chk("ld_lit_bubble", readdata_out, 32'd0);
    chk("ld_lit_bubble_rw", 32'(regwrite_out), 32'd0);

    // Store acked in its third BUSY cycle
    o = blank_op(); o.alu = 32'h200; o.wdata = 32'h55; o.mw = 1'b1; o.d = 2;
    run_op(o);
    chk("st_lit_stall", 32'(obs_stall), 32'd4);
    chk("st_lit_req", 32'(obs_req), 32'd3);
    chk("st_lit_rw", 32'(snap_rw), 32'd0);

    // Load that never gets an ack
    o = blank_op(); o.alu = 32'h300; o.m2r = 1'b1; o.rw = 1'b1; o.d = T + 1;
    run_op(o);
    chk("to_lit_req", 32'(obs_req), 32'd4);
    chk("to_lit_berr", 32'(obs_berr), 32'd1);
    chk("to_lit_stall", 32'(obs_stall), 32'd5);
    chk("to_lit_rdat", snap_rdat, 32'd0);

    // Back-to-back zero-wait loads
    o = blank_op(); o.alu = 32'h400; o.m2r = 1'b1; o.rw = 1'b1; o.rdata = 32'h1; o.d = 0;
    run_op(o); tot_cyc = cyc; tot_req = obs_req;
    o.alu = 32'h404; o.rdata = 32'h2;
    run_op(o); tot_cyc += cyc; tot_req += obs_req;
    chk("b2b_lit_cycles", 32'(tot_cyc), 32'd6);
    chk("b2b_lit_reqs", 32'(tot_req), 32'd2);

    // Reset in the middle of an outstanding access
    o = blank_op(); o.alu = 32'h500; o.m2r = 1'b1; o.rw = 1'b1;
    apply(o); dmem_ack = 1'b0; e_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy_req", 32'(dmem_req), 32'd1);
    #2; reset = 1'b1; #1;
    chk("rst_mid_req", 32'(dmem_req), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_berr", 32'(bus_error), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    carry = '0;

    for (int i = 0; i < 150; i++) run_op(rand_op());

    e_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
